// File: rtl/clock_enable_scheduler.sv
// Round-robin clock-enable generator: one phase accumulator per channel, a single shared adder,
// per-channel wrap tick and phase MSB, and a valid/ready config port that commits in-slot.
module clock_enable_scheduler #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned ACC_WIDTH = 28,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INCREMENT = ACC_WIDTH'(2 ** 24),
  localparam int unsigned CH_BITS = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    run_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [CH_BITS-1:0]      cfg_channel_i,
  input  logic [ACC_WIDTH-1:0]    cfg_increment_i,
  input  logic                    cfg_phase_reset_i,
  output logic                    cfg_err_o,
  output logic [NUM_CHANNELS-1:0] tick_o,
  output logic [NUM_CHANNELS-1:0] phase_msb_o,
  output logic [CH_BITS-1:0]      slot_o
);

  typedef enum logic [0:0] {StIdle, StPending} cfg_state_e;

  logic [ACC_WIDTH-1:0]    acc_q [NUM_CHANNELS];
  logic [ACC_WIDTH-1:0]    acc_d [NUM_CHANNELS];
  logic [ACC_WIDTH-1:0]    inc_q [NUM_CHANNELS];
  logic [ACC_WIDTH-1:0]    inc_d [NUM_CHANNELS];
  logic [CH_BITS-1:0]      slot_q, slot_d;
  logic [NUM_CHANNELS-1:0] tick_q, tick_d;
  logic                    cfg_err_q, cfg_err_d;
  cfg_state_e              state_q, state_d;
  logic [CH_BITS-1:0]      pend_ch_q, pend_ch_d;
  logic [ACC_WIDTH-1:0]    pend_inc_q, pend_inc_d;
  logic                    pend_rst_q, pend_rst_d;

  logic                    commit;
  logic                    ch_in_range;
  logic [ACC_WIDTH-1:0]    sel_acc;
  logic [ACC_WIDTH-1:0]    sel_inc;
  logic [ACC_WIDTH:0]      sum;

  // Slot counter free-runs regardless of run_i so commit latency stays bounded.
  always_comb begin
    slot_d = (slot_q == CH_BITS'(NUM_CHANNELS - 1)) ? '0 : slot_q + CH_BITS'(1);
  end

  assign commit      = (state_q == StPending) && (pend_ch_q == slot_q);
  assign ch_in_range = (32'(cfg_channel_i) < NUM_CHANNELS);

  // Shared adder: operands muxed from the channel owning the current slot.
  always_comb begin
    sel_acc = '0;
    sel_inc = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (slot_q == CH_BITS'(i)) begin
        sel_acc = acc_q[i];
        sel_inc = inc_q[i];
      end
    end
    if (commit) begin
      sel_inc = pend_inc_q;
    end
    sum = {1'b0, sel_acc} + {1'b0, sel_inc};
  end

  always_comb begin
    tick_d = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      acc_d[i] = acc_q[i];
      inc_d[i] = inc_q[i];
      if (slot_q == CH_BITS'(i)) begin
        if (commit) begin
          inc_d[i] = pend_inc_q;
        end
        if (commit && pend_rst_q) begin
          acc_d[i] = '0;
        end else if (run_i) begin
          acc_d[i]  = sum[ACC_WIDTH-1:0];
          tick_d[i] = sum[ACC_WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_ch_d  = pend_ch_q;
    pend_inc_d = pend_inc_q;
    pend_rst_d = pend_rst_q;
    cfg_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid_i) begin
          if (ch_in_range) begin
            pend_ch_d  = cfg_channel_i;
            pend_inc_d = cfg_increment_i;
            pend_rst_d = cfg_phase_reset_i;
            state_d    = StPending;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StPending: begin
        if (commit) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= DEFAULT_INCREMENT;
      end
      slot_q     <= '0;
      tick_q     <= '0;
      cfg_err_q  <= 1'b0;
      state_q    <= StIdle;
      pend_ch_q  <= '0;
      pend_inc_q <= '0;
      pend_rst_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
      slot_q     <= slot_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
      state_q    <= state_d;
      pend_ch_q  <= pend_ch_d;
      pend_inc_q <= pend_inc_d;
      pend_rst_q <= pend_rst_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      phase_msb_o[i] = acc_q[i][ACC_WIDTH-1];
    end
  end

  assign tick_o      = tick_q;
  assign cfg_err_o   = cfg_err_q;
  assign slot_o      = slot_q;
  assign cfg_ready_o = rst_ni && (state_q == StIdle);

  tick_onehot0_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(tick_q));
  no_tick_when_frozen_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !run_i |=> (tick_q == '0));

endmodule

// File: doc/clock_enable_scheduler.md
Name: clock_enable_scheduler

Overview:
Time-multiplexed clock-enable generator for the synth's sub-rate domains: envelopes, LFOs and the sample clock. It keeps one phase accumulator per channel and shares a single adder round-robin across all channels. Each channel produces a one-cycle tick strobe on accumulator wrap and a square-wave phase MSB. Increments and phases can be reconfigured at runtime through a valid/ready write port, with each write committed only in that channel's own slot.

Parameters:
NUM_CHANNELS, 4, number of scheduled channels; must be >= 2
ACC_WIDTH, 28, phase accumulator width in bits
DEFAULT_INCREMENT, 2**24, per-channel increment loaded at reset
CH_BITS, $clog2(NUM_CHANNELS), channel index width (derived, not overridden)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
run  input  1  1 = accumulators advance; 0 = phases frozen
cfg_valid  input  1  config write request
cfg_ready  output  1  config port can accept a write
cfg_channel  input  CH_BITS  target channel of the write
cfg_increment  input  ACC_WIDTH  new increment for the target channel
cfg_phase_reset  input  1  1 = clear the target accumulator on commit
cfg_err  output  1  one-cycle pulse: write targeted a nonexistent channel
tick  output  NUM_CHANNELS  per-channel one-cycle wrap strobe
phase_msb  output  NUM_CHANNELS  per-channel accumulator MSB
slot  output  CH_BITS  channel currently owning the adder

Behaviour:
- Reset is synchronous: sampled at posedge clk while rst_n=0. On reset:
  - all accumulators = 0; all increments = DEFAULT_INCREMENT;
  - slot = 0; tick = 0; phase_msb = 0; cfg_err = 0;
  - config FSM = IDLE; any pending write is discarded.
  - cfg_ready is forced 0 while rst_n=0.
- Slot counter:
  - Advances 0,1,...,NUM_CHANNELS-1,0 on every clock, independent of run.
  - Channel i is therefore serviced once every NUM_CHANNELS clocks.
- Service of channel s = slot at an edge, with run=1 and no commit for s:
  - {carry, acc[s]} <= acc[s] + inc[s], modulo 2^ACC_WIDTH.
  - tick[s] = carry in the following cycle; all other tick bits are 0.
- With run=0: no accumulator changes and tick = 0. The slot counter and the config FSM keep running.
- phase_msb[i] = acc[i][ACC_WIDTH-1], registered.
- Output frequency: tick rate = f_clk * inc / (NUM_CHANNELS * 2^ACC_WIDTH).
- At most one tick bit is high per cycle. Each tick is exactly one cycle wide.
- Config FSM, states IDLE and PENDING:
  - IDLE: cfg_ready = 1.
    - cfg_valid=1 and cfg_channel < NUM_CHANNELS: capture channel, increment and phase_reset; go to PENDING.
    - cfg_valid=1 and cfg_channel >= NUM_CHANNELS: cfg_err = 1 for the next cycle; no state change; stay IDLE.
  - PENDING: cfg_ready = 0. Commit on the first edge where slot == captured channel, including the edge right after acceptance if the slot already matches; then return to IDLE.
  - Commit latency is 1..NUM_CHANNELS clocks after acceptance.
- Commit replaces that channel's normal service for that slot:
  - inc <= new increment.
  - phase_reset=1: acc <= 0 and no tick, regardless of run.
  - phase_reset=0: if run=1, acc <= acc + new increment, and tick is generated on carry as normal; if run=0, acc holds.
- Increment 0: the channel never ticks. Increment 2^ACC_WIDTH-1: the channel ticks on every service except the first one from acc=0.

Test Plan:
1. Reset, run=1, defaults, N=4 -> tick[0] first high in cycle 62 after reset release (16th service). Then tick[0] period = 64 clocks; tick[1..3] lag tick[0] by 1..3 cycles. phase_msb[0] has a 64-clock period.
2. At slot=3: write ch2, inc=2^27, phase_reset=0 -> cfg_ready low for 3 cycles, commit at slot 2, then tick[2] period = 8 clocks. Check the write while PENDING is held off via cfg_ready=0.
3. Write ch1 with inc=2^28-1, then inc=0 with phase_reset=1 -> with the max increment, ticks on every service after the first from 0. After inc=0 with phase reset: tick[1] never asserts and phase_msb[1] = 0.
4. run=0 for 100 cycles mid-stream -> tick = 0 and phases frozen. A write issued during the freeze still commits within 4 cycles. After run=1, the tick schedule resumes from the frozen phase with no lost or extra ticks.
5. NUM_CHANNELS=3, write cfg_channel=3 -> cfg_err pulses for exactly 1 cycle, cfg_ready stays 1, and no channel state changes.
6. Assert rst_n=0 while PENDING -> the write is discarded. After release: all increments = DEFAULT_INCREMENT, slot = 0, cfg_ready = 1.
